uart_tx_arbiter: RTL and testbench

//  Shares one UART transmit path among N byte-stream requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM state encodings,
// default parameter values and a small sizing helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEF_N          = 4;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT    = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: first set request bit scanning
// upward from ptr_i+1 (mod N), returned as one-hot, index and an any flag.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int  idx;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = IW'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter of N byte streams onto one UART TX FIFO
// write port, with an inter-packet gap and a stall timeout that revokes the grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           fifo_wr,
  output logic [7:0]     fifo_wdata,
  input  logic           fifo_full,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(max_int(TIMEOUT, GAP_CYCLES) + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  logic          own_vld;
  logic          own_last;
  logic [7:0]    own_dat;
  logic          in_xfer;
  logic          accept;
  logic          stall_hit;

  uart_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // ptr_q holds the current owner for the whole XFER, so it doubles as the lane select.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q == IW'(i)) begin
        own_vld  = req_valid[i];
        own_last = req_last[i];
        own_dat  = req_data[8*i +: 8];
      end
    end
  end

  assign in_xfer    = (state_q == ST_XFER);
  assign accept     = in_xfer & own_vld & ~fifo_full;
  assign stall_hit  = in_xfer & ~accept & (int'(cnt_q) >= TIMEOUT - 1);

  assign req_ready  = in_xfer ? (grant_q & {N{~fifo_full}}) : '0;
  assign fifo_wr    = accept;
  assign fifo_wdata = own_dat;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign timeout    = stall_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_i && pick_any) begin
          state_d = ST_XFER;
          grant_d = pick_gnt;
          ptr_d   = pick_idx;
        end
      end
      ST_XFER: begin
        if (accept) begin
          cnt_d = '0;
          if (own_last) begin
            grant_d = '0;
            state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end else if (stall_hit) begin
          // ptr stays on the revoked owner so it becomes lowest priority next round
          cnt_d   = '0;
          grant_d = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (int'(cnt_q) >= GAP_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-lane byte sources feed the DUT and
// a scoreboard of expected {lane, byte} writes is checked on every fifo_wr.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TO  = 8;

  typedef logic [8:0] byte9_t;
  typedef struct packed {
    logic [3:0] lane;
    logic [7:0] dat;
  } sb_t;

  logic           clk;
  logic           rst_i;
  logic           en_i;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wr;
  logic [7:0]     fifo_wdata;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;

  byte9_t       lane_q [N][$];
  sb_t          exp_q [$];
  logic [N-1:0] acc_snap;
  int           n_cmp;
  int           n_bad;

  uart_tx_arbiter #(.N(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write must match the oldest expected {lane, byte}.
  always @(negedge clk) begin
    sb_t got;
    sb_t e;
    acc_snap = req_valid & req_ready;
    if (fifo_wr === 1'b1) begin
      got.lane = 4'hF;
      for (int i = 0; i < N; i++) if (grant[i] === 1'b1) got.lane = 4'(i);
      got.dat = fifo_wdata;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got lane %0d byte %02h, required no write", got.lane, got.dat);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL sb_write: got lane %0d byte %02h, required lane %0d byte %02h",
                   got.lane, got.dat, e.lane, e.dat);
        end
      end
    end
  end

  task automatic drive_inputs();
    byte9_t b9;
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        b9 = lane_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = b9[7:0];
        req_last[i]        = b9[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: pop bytes accepted in the cycle just ended, present the next ones.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_snap[i]) void'(lane_q[i].pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic push(input int lane, input logic last, input logic [7:0] d, input bit expect_wr);
    sb_t e;
    lane_q[lane].push_back({last, d});
    if (expect_wr) begin
      e.lane = 4'(lane);
      e.dat  = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    bit lanes_empty;
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      lanes_empty = 1'b1;
      for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) lanes_empty = 1'b0;
      if (exp_q.size() == 0 && busy === 1'b0 && lanes_empty) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
    n_cmp++; if (fifo_wr !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_wr: got %b, required 0", fifo_wr); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single_packet();
    bit gap_ok;
    bit ok;
    push(0, 1'b0, 8'h11, 1'b1);
    push(0, 1'b0, 8'h22, 1'b1);
    push(0, 1'b1, 8'h33, 1'b1);
    drive_inputs();
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL pkt_grant_latency: got %b, required 0000", grant); end
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL pkt_grant: got %b, required 0001", grant); end
    for (int b = 0; b < 3; b++) begin
      if (b > 0) step();
      n_cmp++; if (fifo_wr !== 1'b1) begin n_bad++; $display("FAIL pkt_wr_byte%0d: got %b, required 1", b, fifo_wr); end
    end
    step();
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b1 || fifo_wr !== 1'b0)
      begin n_bad++; $display("FAIL pkt_gap_entry: got grant %b busy %b wr %b, required 0000 1 0", grant, busy, fifo_wr); end
    gap_ok = 1'b1;
    for (int c = 0; c < GAP - 1; c++) begin
      step();
      if (busy !== 1'b1) gap_ok = 1'b0;
    end
    n_cmp++; if (!gap_ok) begin n_bad++; $display("FAIL pkt_gap_busy: got early busy drop, required busy for %0d cycles", GAP); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pkt_gap_end: got busy %b, required 0", busy); end
    wait_idle(10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pkt_drain: got %0d pending writes, required 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    bit repushed;
    bit done;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    push(0, 1'b1, 8'h41, 1'b1);
    push(1, 1'b1, 8'h42, 1'b1);
    push(2, 1'b1, 8'h43, 1'b1);
    exp_q.push_back('{lane: 4'd0, dat: 8'h44});
    drive_inputs();
    repushed = 1'b0;
    done     = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (!repushed && lane_q[0].size() == 0) begin
        lane_q[0].push_back({1'b1, 8'h44});
        drive_inputs();
        repushed = 1'b1;
      end
      if (exp_q.size() == 0 && busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rr_drain: got %0d pending writes, required 0", exp_q.size()); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    push(1, 1'b0, 8'hA1, 1'b1);
    push(1, 1'b0, 8'hA2, 1'b1);
    push(1, 1'b0, 8'hA3, 1'b1);
    push(1, 1'b1, 8'hA4, 1'b1);
    drive_inputs();
    step();
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL full_grant: got %b, required 0010", grant); end
    step();
    fifo_full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (req_ready !== 4'b0000 || fifo_wr !== 1'b0 || grant !== 4'b0010) begin
        n_bad++;
        $display("FAIL full_stall%0d: got ready %b wr %b grant %b, required 0000 0 0010", c, req_ready, fifo_wr, grant);
      end
      step();
    end
    fifo_full = 1'b0;
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_drain: got %0d pending writes, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit quiet;
    bit ok;
    push(1, 1'b0, 8'hB1, 1'b1);
    drive_inputs();
    step();
    n_cmp++; if (grant !== 4'b0010 || fifo_wr !== 1'b1)
      begin n_bad++; $display("FAIL to_grant: got grant %b wr %b, required 0010 1", grant, fifo_wr); end
    push(2, 1'b1, 8'hC2, 1'b1);
    drive_inputs();
    step();
    quiet = 1'b1;
    for (int k = 1; k < TO; k++) begin
      if (timeout !== 1'b0) quiet = 1'b0;
      step();
    end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL to_early: got early timeout pulse, required none before stall %0d", TO); end
    n_cmp++; if (timeout !== 1'b1 || grant !== 4'b0010)
      begin n_bad++; $display("FAIL to_pulse: got timeout %b grant %b, required 1 0010", timeout, grant); end
    step();
    n_cmp++; if (timeout !== 1'b0 || grant !== 4'b0000 || busy !== 1'b1)
      begin n_bad++; $display("FAIL to_revoke: got timeout %b grant %b busy %b, required 0 0000 1", timeout, grant, busy); end
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_next: got %0d pending writes, required 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    bit held;
    bit ok;
    en_i = 1'b0;
    push(3, 1'b0, 8'hD1, 1'b1);
    push(3, 1'b1, 8'hD2, 1'b1);
    drive_inputs();
    held = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (grant !== 4'b0000 || busy !== 1'b0) held = 1'b0;
      step();
    end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL en_block: got grant %b busy %b, required 0000 0", grant, busy); end
    en_i = 1'b1;
    step();
    n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL en_grant: got %b, required 1000", grant); end
    en_i = 1'b0;
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL en_midpkt: got %0d pending writes, required 0", exp_q.size()); end
    en_i = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    push(0, 1'b0, 8'hE1, 1'b1);
    push(0, 1'b0, 8'hE2, 1'b0);
    push(0, 1'b1, 8'hE3, 1'b0);
    drive_inputs();
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rst_pre_grant: got %b, required 0001", grant); end
    rst_i = 1'b1;
    step();
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0 || fifo_wr !== 1'b0)
      begin n_bad++; $display("FAIL rst_mid: got grant %b busy %b wr %b, required 0000 0 0", grant, busy, fifo_wr); end
    lane_q[0].delete();
    rst_i = 1'b0;
    push(0, 1'b1, 8'hF0, 1'b1);
    push(1, 1'b1, 8'hF1, 1'b1);
    drive_inputs();
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rst_tie: got %b, required 0001", grant); end
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_drain: got %0d pending writes, required 0", exp_q.size()); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    acc_snap  = '0;
    rst_i     = 1'b1;
    en_i      = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    drive_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_timeout();
    test_enable();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
